// File: rtl/fp16_pkg.sv
// Shared fp16 definitions for the reciprocal arbiter: field widths, special encodings, clog2.
package fp16_pkg;

    localparam int unsigned FP16_W     = 16;
    localparam int unsigned FP16_EXP_W = 5;
    localparam int unsigned FP16_MAN_W = 10;

    localparam logic [FP16_W-1:0] FP16_QNAN    = 16'h7E01;
    localparam logic [FP16_W-1:0] FP16_POS_INF = 16'h7C00;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp16_recip.sv
// Combinational fp16 reciprocal, round-to-nearest mantissa.
// Subnormal inputs are treated as signed zero; out-of-range results go to inf or signed zero.
module fp16_recip
    import fp16_pkg::*;
(
    input  logic [FP16_W-1:0] a,
    output logic [FP16_W-1:0] recip_c
);

    logic                  sgn;
    logic [FP16_EXP_W-1:0] exp_in;
    logic [FP16_MAN_W-1:0] man_in;
    logic [FP16_MAN_W:0]   sig;
    logic [FP16_MAN_W-1:0] man_out;
    int                    exp_out;

    always_comb begin
        sgn     = a[FP16_W-1];
        exp_in  = a[FP16_W-2 -: FP16_EXP_W];
        man_in  = a[FP16_MAN_W-1:0];
        sig     = {1'b1, man_in};
        // round(2^21 / sig) = 2/sig with 10 fraction bits; the hidden bit falls off the top
        man_out = FP16_MAN_W'((22'h20_0000 + 22'(sig >> 1)) / 22'(sig));
        exp_out = ((man_in == '0) ? 30 : 29) - int'(exp_in);
        recip_c = {sgn, 15'd0};
        if (exp_in == '1) begin
            recip_c = (man_in != '0) ? FP16_QNAN : {sgn, 15'd0};
        end else if (exp_in == '0) begin
            recip_c = {sgn, FP16_POS_INF[FP16_W-2:0]};
        end else if (exp_out >= 31) begin
            recip_c = {sgn, FP16_POS_INF[FP16_W-2:0]};
        end else if (exp_out <= 0) begin
            recip_c = {sgn, 15'd0};
        end else begin
            recip_c = {sgn, FP16_EXP_W'(exp_out), man_out};
        end
    end

endmodule

// File: rtl/fp16_rr_arb.sv
// Combinational round-robin picker: first requester above ptr (with wrap) wins.
module fp16_rr_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [IDW-1:0]     idx_c
);

    logic [IDW-1:0] cand;

    // Scan farthest offset first so the nearest requester after ptr is the last writer.
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        cand    = '0;
        for (int unsigned off = NUM_REQ; off >= 1; off--) begin
            cand = IDW'((32'(ptr) + off) % NUM_REQ);
            if (req[cand]) begin
                grant_c       = '0;
                grant_c[cand] = 1'b1;
                idx_c         = cand;
            end
        end
    end

endmodule

// File: rtl/fp16_recip_arb.sv
// Round-robin share of one fp16 reciprocal across NUM_REQ requesters, LAT-stage stallable pipeline.
// Optional per-requester grant counters when FP16_RECIP_ARB_STATS_EN is defined.
module fp16_recip_arb
    import fp16_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LAT     = 3,
    parameter int unsigned IDW     = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [FP16_W*NUM_REQ-1:0] req_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [FP16_W-1:0]         rsp_data,
    output logic [IDW-1:0]            rsp_id,
    output logic                      busy
`ifdef FP16_RECIP_ARB_STATS_EN
    ,
    output logic [CNT_W*NUM_REQ-1:0]  grant_cnt
`endif
);

    if (NUM_REQ < 2 || LAT < 1 || IDW != clog2(NUM_REQ) || CNT_W < 1) begin : g_bad_param
        $error("fp16_recip_arb: illegal parameter combination");
    end

    typedef struct packed {
        logic              valid;
        logic [IDW-1:0]    id;
        logic [FP16_W-1:0] data;
    } stage_t;

    stage_t              stg_q [LAT];
    stage_t              stg_d [LAT];
    logic [IDW-1:0]      ptr_q;
    logic [IDW-1:0]      ptr_d;
    logic                busy_q;
    logic                busy_d;
    logic [NUM_REQ-1:0]  grant;
    logic [IDW-1:0]      gnt_idx;
    logic [FP16_W-1:0]   sel_data;
    logic [FP16_W-1:0]   recip;
    logic                adv;
    logic                accept;

    fp16_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .grant_c (grant),
        .idx_c   (gnt_idx)
    );

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data = req_data[FP16_W*i +: FP16_W];
            end
        end
    end

    fp16_recip u_recip (
        .a       (sel_data),
        .recip_c (recip)
    );

    // Whole pipeline moves or whole pipeline holds; no accepts while reset is asserted.
    assign adv       = !stg_q[LAT-1].valid || rsp_ready;
    assign req_ready = grant & {NUM_REQ{adv & rst_n}};
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        stg_d = stg_q;
        ptr_d = ptr_q;
        if (adv) begin
            for (int unsigned i = 1; i < LAT; i++) begin
                stg_d[i] = stg_q[i-1];
            end
            stg_d[0] = '0;
            if (accept) begin
                stg_d[0].valid = 1'b1;
                stg_d[0].id    = gnt_idx;
                stg_d[0].data  = recip;
                ptr_d          = gnt_idx;
            end
        end
        busy_d = 1'b0;
        for (int unsigned i = 0; i < LAT; i++) begin
            busy_d = busy_d | stg_d[i].valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                stg_q[i] <= '0;
            end
            ptr_q  <= IDW'(NUM_REQ - 1);
            busy_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < LAT; i++) begin
                stg_q[i] <= stg_d[i];
            end
            ptr_q  <= ptr_d;
            busy_q <= busy_d;
        end
    end

    assign rsp_valid = stg_q[LAT-1].valid;
    assign rsp_data  = stg_q[LAT-1].data;
    assign rsp_id    = stg_q[LAT-1].id;
    assign busy      = busy_q;

`ifdef FP16_RECIP_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_REQ];

    // Saturating accept counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (accept && cnt_q[gnt_idx] != '1) begin
            cnt_q[gnt_idx] <= cnt_q[gnt_idx] + CNT_W'(1);
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            grant_cnt[CNT_W*i +: CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_fp16_recip_arb.sv
// Self-checking bench for fp16_recip_arb: vector table, corner sequences, randomized traffic vs reference model.
module tb_fp16_recip_arb;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned LAT     = 3;
    localparam int unsigned IDW     = 2;
    localparam int unsigned CNT_W   = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [16*NUM_REQ-1:0]  req_data;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [15:0]            rsp_data;
    logic [IDW-1:0]         rsp_id;
    logic                   busy;
`ifdef FP16_RECIP_ARB_STATS_EN
    logic [CNT_W*NUM_REQ-1:0] grant_cnt;
`endif

    fp16_recip_arb #(
        .NUM_REQ (NUM_REQ),
        .LAT     (LAT),
        .IDW     (IDW),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
`ifdef FP16_RECIP_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          id;
        logic [15:0] data;
    } rec_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] y;
    } vec_t;

    int   n_tests  = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   m_last   = NUM_REQ - 1;
    int   done_cnt = 0;
    rec_t exp_q[$];
    rec_t rsp_log[$];
    rec_t acc_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference reciprocal from real arithmetic and explicit renormalisation.
    function automatic logic [15:0] model_recip(input logic [15:0] a);
        int   e, f, k, mant;
        real  x, t;
        logic s;
        s = a[15];
        e = int'(a[14:10]);
        f = int'(a[9:0]);
        if (e == 31) return (f != 0) ? 16'h7E01 : {s, 15'h0000};
        if (e == 0) return {s, 15'h7C00};
        x = 1.0 + real'(f) / 1024.0;
        for (int i = 15; i < e; i++) x = x * 2.0;
        for (int i = e; i < 15; i++) x = x / 2.0;
        t = 1.0 / x;
        k = 0;
        while (t >= 2.0) begin t = t / 2.0; k++; end
        while (t < 1.0) begin t = t * 2.0; k--; end
        mant = int'($floor((t - 1.0) * 1024.0 + 0.5));
        if (mant == 1024) begin mant = 0; k++; end
        if (k + 15 >= 31) return {s, 15'h7C00};
        if (k + 15 <= 0) return {s, 15'h0000};
        return {s, 5'(k + 15), 10'(mant)};
    endfunction

    // Scoreboard: arbitration order, handshakes, busy, and in-order results.
    always @(negedge clk) begin
        int                 eg;
        int                 ai;
        logic [NUM_REQ-1:0] er;
        rec_t               e;
        if (!rst_n) begin
            check("rst_req_ready", 32'(req_ready), 32'(0));
            exp_q.delete();
            m_last = NUM_REQ - 1;
        end else begin
            check("busy", 32'(busy), 32'(exp_q.size() != 0));
            eg = -1;
            for (int k = NUM_REQ; k >= 1; k--) begin
                if (req_valid[(m_last + k) % NUM_REQ]) eg = (m_last + k) % NUM_REQ;
            end
            er = '0;
            if (eg >= 0 && (!rsp_valid || rsp_ready)) er[eg] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(er));
            if (rsp_valid && rsp_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected got id=%0d data=%h exp=none", rsp_id, rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_id !== IDW'(e.id) || rsp_data !== e.data) begin
                        n_fail++;
                        $display("FAIL rsp got id=%0d data=%h exp id=%0d data=%h", rsp_id, rsp_data, e.id, e.data);
                    end
                end
                rsp_log.push_back('{cyc, int'(rsp_id), rsp_data});
            end
            ai = -1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) ai = i;
            end
            if (ai >= 0) begin
                exp_q.push_back('{cyc, ai, model_recip(req_data[16*ai +: 16])});
                acc_log.push_back('{cyc, ai, req_data[16*ai +: 16]});
                m_last = ai;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one operand from requester r and hold it until accepted.
    task automatic send(input int r, input logic [15:0] d);
        int n;
        n = 0;
        req_data[16*r +: 16] = d;
        req_valid[r] = 1'b1;
        @(negedge clk);
        while (!(req_ready[r] && rst_n) && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout req=%0d got=stuck exp=accept", r);
        end
        @(posedge clk);
        #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic run_req(input int r, input int n_ops, input bit rnd);
        for (int k = 0; k < n_ops; k++) begin
            if (rnd) begin
                repeat ($urandom_range(0, 3)) tick(1);
                send(r, 16'($urandom));
            end else begin
                send(r, 16'h3C00 + 16'(r * 4 + k));
            end
        end
        done_cnt++;
    endtask

    task automatic wait_done(input int target, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < 5000) begin
            tick(1);
            n++;
        end
        check(name, 32'(done_cnt), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[$];
        logic [15:0]   held_d;
        logic [IDW-1:0] held_id;
        int            n;

        vt.push_back('{16'h3C00, 16'h3C00});
        vt.push_back('{16'h0000, 16'h7C00});
        vt.push_back('{16'h8000, 16'hFC00});
        vt.push_back('{16'h7E00, 16'h7E01});
        vt.push_back('{16'h7C00, 16'h0000});
        vt.push_back('{16'hFC00, 16'h8000});
        vt.push_back('{16'h4000, 16'h3800});
        vt.push_back('{16'hC000, 16'hB800});
        vt.push_back('{16'h4200, 16'h3555});
        vt.push_back('{16'h0400, 16'h7400});
        vt.push_back('{16'h7BFF, 16'h0000});
        vt.push_back('{16'h3BFF, 16'h3C01});
        vt.push_back('{16'h0001, 16'h7C00});
        vt.push_back('{16'h8001, 16'hFC00});
        vt.push_back('{16'hFE00, 16'h7E01});

        rst_n     = 1'b0;
        req_valid = '1;
        req_data  = '0;
        rsp_ready = 1'b1;
        tick(2);
        @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
        check("reset_rsp_data", 32'(rsp_data), 32'(0));
        check("reset_rsp_id", 32'(rsp_id), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_req_ready", 32'(req_ready), 32'(0));
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b1;

        // Single op with latency measurement.
        rsp_log.delete();
        acc_log.delete();
        send(1, 16'h4000);
        tick(LAT + 2);
        check("single_count", 32'(rsp_log.size()), 32'(1));
        if (rsp_log.size() >= 1 && acc_log.size() >= 1) begin
            check("single_data", 32'(rsp_log[0].data), 32'h3800);
            check("single_id", 32'(rsp_log[0].id), 32'(1));
            check("single_latency", 32'(rsp_log[0].cyc - acc_log[0].cyc), 32'(LAT));
        end

        // Vector table back-to-back from requester 0.
        rsp_log.delete();
        foreach (vt[i]) send(0, vt[i].a);
        tick(LAT + 3);
        check("table_count", 32'(rsp_log.size()), 32'(vt.size()));
        for (int i = 0; i < vt.size() && i < rsp_log.size(); i++) begin
            check($sformatf("table_data[%0d]", i), 32'(rsp_log[i].data), 32'(vt[i].y));
            check($sformatf("table_id[%0d]", i), 32'(rsp_log[i].id), 32'(0));
            if (i > 0) check($sformatf("table_rate[%0d]", i), 32'(rsp_log[i].cyc - rsp_log[i-1].cyc), 32'(1));
        end

        // Backpressure with a full pipeline.
        rsp_ready = 1'b0;
        rsp_log.delete();
        done_cnt  = 0;
        fork
            run_req(2, LAT + 1, 1'b0);
        join_none
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin n++; @(negedge clk); end
        check("bp_fill", 32'(rsp_valid), 32'(1));
        held_d  = rsp_data;
        held_id = rsp_id;
        repeat (5) begin
            @(negedge clk);
            check("bp_req_ready", 32'(req_ready), 32'(0));
            check("bp_data_hold", 32'(rsp_data), 32'(held_d));
            check("bp_id_hold", 32'(rsp_id), 32'(held_id));
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_done(1, "bp_sender_done");
        tick(LAT + 2);
        check("bp_rsp_count", 32'(rsp_log.size()), 32'(LAT + 1));
        check("bp_drained", 32'(exp_q.size()), 32'(0));

        // Reset with three ops in flight.
        rsp_ready = 1'b0;
        send(0, 16'h4000);
        send(1, 16'h4200);
        send(2, 16'h4400);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        rsp_log.delete();
        acc_log.delete();
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        tick(6);
        check("midrst_no_stale", 32'(rsp_log.size()), 32'(0));

        // Fairness: all requesters contend for 8 accepts.
        done_cnt = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            fork
                automatic int r = i;
                run_req(r, 2, 1'b0);
            join_none
        end
        wait_done(NUM_REQ, "fair_done");
        tick(LAT + 2);
        check("fair_count", 32'(acc_log.size()), 32'(8));
        for (int i = 0; i < 8 && i < acc_log.size(); i++) begin
            check($sformatf("fair_order[%0d]", i), 32'(acc_log[i].id), 32'(i % NUM_REQ));
        end
`ifdef FP16_RECIP_ARB_STATS_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            check($sformatf("fair_cnt[%0d]", i), 32'(grant_cnt[i*CNT_W +: CNT_W]), 32'(2));
        end
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("cnt_cleared", 32'(grant_cnt), 32'(0));
        for (int k = 0; k < 20; k++) send(2, 16'h4000);
        tick(LAT + 2);
        check("cnt_sat", 32'(grant_cnt[2*CNT_W +: CNT_W]), 32'hF);
        check("cnt_other", 32'(grant_cnt[0 +: CNT_W]), 32'(0));
`endif

        // Randomized traffic with random response backpressure.
        done_cnt = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            fork
                automatic int r = i;
                run_req(r, 40, 1'b1);
            join_none
        end
        n = 0;
        while (done_cnt < NUM_REQ && n < 5000) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick(1);
            n++;
        end
        rsp_ready = 1'b1;
        check("rand_done", 32'(done_cnt), 32'(NUM_REQ));
        tick(LAT + 4);
        check("rand_drained", 32'(exp_q.size()), 32'(0));
        check("rand_idle", 32'(busy), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
